// File: rtl/traffic_phase_sequencer.sv
// N-approach traffic phase sequencer: GREEN -> YELLOW -> ALL_RED per approach,
// round-robin by default, with per-approach priority preemption and green extension.
module traffic_phase_sequencer #(
  parameter int unsigned NUM_APPR  = 4,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned GREEN_T   = 20,
  parameter int unsigned MIN_GREEN = 5,
  parameter int unsigned MAX_GREEN = 40,
  parameter int unsigned YELLOW_T  = 4,
  parameter int unsigned ALLRED_T  = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tick,
  input  logic [NUM_APPR-1:0]         priority_req,
  output logic [NUM_APPR-1:0]         green,
  output logic [NUM_APPR-1:0]         yellow,
  output logic                        all_red,
  output logic [$clog2(NUM_APPR)-1:0] active_idx,
  output logic                        phase_done
);

  localparam int unsigned IDX_W = $clog2(NUM_APPR);

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] GREEN_LD   = CNT_W'(GREEN_T - 1);
  localparam logic [CNT_W-1:0] YELLOW_LD  = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] ALLRED_LD  = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] MIN_G      = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] MAX_G      = CNT_W'(MAX_GREEN);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_APPR - 1);

  typedef enum logic [1:0] {
    S_ALL_RED = 2'd0,
    S_GREEN   = 2'd1,
    S_YELLOW  = 2'd2
  } state_e;

  state_e              state_q,     state_d;
  logic [CNT_W-1:0]    remaining_q, remaining_d;
  logic [CNT_W-1:0]    elapsed_q,   elapsed_d;
  logic [IDX_W-1:0]    last_q,      last_d;
  logic [IDX_W-1:0]    active_q,    active_d;
  logic [NUM_APPR-1:0] green_q,     green_d;
  logic [NUM_APPR-1:0] yellow_q,    yellow_d;
  logic                all_red_q,   all_red_d;

  logic [NUM_APPR-1:0] active_oh;
  logic [IDX_W-1:0]    next_idx;
  logic                others_req;
  logic                extend;
  logic                exit_now;

  // Lowest requesting approach other than the one just served, else round-robin.
  function automatic logic [IDX_W-1:0] pick_next(input logic [NUM_APPR-1:0] req,
                                                 input logic [IDX_W-1:0]    last);
    logic [IDX_W-1:0] nxt;
    logic             found;
    found = 1'b0;
    nxt   = (last == LAST_IDX) ? '0 : last + IDX_W'(1);
    for (int unsigned i = 0; i < NUM_APPR; i++) begin
      if (!found && req[i] && (IDX_W'(i) != last)) begin
        nxt   = IDX_W'(i);
        found = 1'b1;
      end
    end
    return nxt;
  endfunction

  always_comb begin
    active_oh  = NUM_APPR'(1) << active_q;
    others_req = |(priority_req & ~active_oh);
    extend     = priority_req[active_q] && !others_req;
    next_idx   = pick_next(priority_req, last_q);
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    elapsed_d   = elapsed_q;
    last_d      = last_q;
    active_d    = active_q;
    green_d     = green_q;
    yellow_d    = yellow_q;
    all_red_d   = all_red_q;
    exit_now    = 1'b0;

    if (tick) begin
      case (state_q)
        S_ALL_RED: begin
          if (remaining_q == '0) begin
            exit_now    = 1'b1;
            state_d     = S_GREEN;
            remaining_d = GREEN_LD;
            elapsed_d   = CNT_ONE;
            last_d      = next_idx;
            active_d    = next_idx;
            green_d     = NUM_APPR'(1) << next_idx;
            yellow_d    = '0;
            all_red_d   = 1'b0;
          end else begin
            remaining_d = remaining_q - CNT_ONE;
          end
        end

        S_GREEN: begin
          // Extension freezes the nominal timer; elapsed keeps the ceiling honest.
          if ((others_req && (elapsed_q >= MIN_G)) ||
              (elapsed_q >= MAX_G) ||
              ((remaining_q == '0) && !extend)) begin
            exit_now    = 1'b1;
            state_d     = S_YELLOW;
            remaining_d = YELLOW_LD;
            green_d     = '0;
            yellow_d    = active_oh;
          end else begin
            if (!extend) begin
              remaining_d = remaining_q - CNT_ONE;
            end
            elapsed_d = (elapsed_q >= MAX_G) ? elapsed_q : elapsed_q + CNT_ONE;
          end
        end

        S_YELLOW: begin
          if (remaining_q == '0) begin
            exit_now    = 1'b1;
            state_d     = S_ALL_RED;
            remaining_d = ALLRED_LD;
            yellow_d    = '0;
            all_red_d   = 1'b1;
          end else begin
            remaining_d = remaining_q - CNT_ONE;
          end
        end

        default: begin
          state_d     = S_ALL_RED;
          remaining_d = ALLRED_LD;
          green_d     = '0;
          yellow_d    = '0;
          all_red_d   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_ALL_RED;
      remaining_q <= ALLRED_LD;
      elapsed_q   <= '0;
      last_q      <= LAST_IDX;
      active_q    <= '0;
      green_q     <= '0;
      yellow_q    <= '0;
      all_red_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      elapsed_q   <= elapsed_d;
      last_q      <= last_d;
      active_q    <= active_d;
      green_q     <= green_d;
      yellow_q    <= yellow_d;
      all_red_q   <= all_red_d;
    end
  end

  assign green      = green_q;
  assign yellow     = yellow_q;
  assign all_red    = all_red_q;
  assign active_idx = active_q;
  assign phase_done = exit_now;

  a_one_lamp_kind: assert property (@(posedge clk) disable iff (rst)
    $onehot0({|green_q, |yellow_q, all_red_q}));
  a_green_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(green_q));
  a_yellow_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(yellow_q));

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Bench for traffic_phase_sequencer: directed scenarios plus random priority/tick
// traffic, every cycle compared against a phase-level reference model.
module tb_traffic_phase_sequencer;

  localparam int N    = 4;
  localparam int GT   = 20;
  localparam int MING = 5;
  localparam int MAXG = 40;
  localparam int YT   = 4;
  localparam int ART  = 2;

  logic         clk  = 1'b0;
  logic         rst  = 1'b1;
  logic         tick = 1'b0;
  logic [N-1:0] prio = '0;
  logic [N-1:0] green, yellow;
  logic         all_red, phase_done;
  logic [1:0]   active_idx;

  always #5 clk = ~clk;

  traffic_phase_sequencer #(
    .NUM_APPR (N),
    .CNT_W    (8),
    .GREEN_T  (GT),
    .MIN_GREEN(MING),
    .MAX_GREEN(MAXG),
    .YELLOW_T (YT),
    .ALLRED_T (ART)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .priority_req(prio),
    .green       (green),
    .yellow      (yellow),
    .all_red     (all_red),
    .active_idx  (active_idx),
    .phase_done  (phase_done)
  );

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  // Reference model: phase kind, ticks completed in phase, ticks that were not extensions.
  int m_phase;   // 0 all-red, 1 green, 2 yellow
  int m_ticks;
  int m_nonext;
  int m_idx;
  int m_last;
  bit m_valid = 1'b0;

  logic [N-1:0] rec_g [0:255];
  logic [N-1:0] rec_y [0:255];
  logic         rec_r [0:255];
  logic         rec_d [0:255];
  logic [1:0]   rec_a [0:255];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic int pick(input logic [N-1:0] p, input int last);
    for (int i = 0; i < N; i++) if (p[i] && i != last) return i;
    return (last + 1) % N;
  endfunction

  function automatic bit model_ext();
    logic [N-1:0] own;
    own = 4'b0001 << m_idx;
    return ((prio & own) != 0) && ((prio & ~own) == 0);
  endfunction

  function automatic bit model_done();
    int  n;
    logic [N-1:0] own;
    if (!tick) return 1'b0;
    case (m_phase)
      0: return (m_ticks + 1) == ART;
      2: return (m_ticks + 1) == YT;
      default: begin
        n   = m_ticks + 1;
        own = 4'b0001 << m_idx;
        if (((prio & ~own) != 0) && n >= MING) return 1'b1;
        if (n >= MAXG) return 1'b1;
        return !model_ext() && (m_nonext + 1) >= GT;
      end
    endcase
  endfunction

  task automatic step();
    bit           d, e;
    logic [N-1:0] eg, ey;
    @(negedge clk);
    d = model_done();
    e = model_ext();
    if (m_valid) begin
      eg = (m_phase == 1) ? (4'b0001 << m_idx) : 4'b0000;
      ey = (m_phase == 2) ? (4'b0001 << m_idx) : 4'b0000;
      chk("green", green, eg);
      chk("yellow", yellow, ey);
      chk("all_red", all_red, m_phase == 0);
      chk("active_idx", active_idx, m_idx);
      chk("phase_done", phase_done, d);
    end
    if (cyc < 256) begin
      rec_g[cyc] = green;
      rec_y[cyc] = yellow;
      rec_r[cyc] = all_red;
      rec_d[cyc] = phase_done;
      rec_a[cyc] = active_idx;
    end
    @(posedge clk);
    if (rst) begin
      m_phase = 0; m_ticks = 0; m_nonext = 0; m_idx = 0; m_last = N - 1; m_valid = 1'b1;
    end else if (tick) begin
      if (d) begin
        case (m_phase)
          0: begin m_idx = pick(prio, m_last); m_last = m_idx; m_phase = 1; end
          1: m_phase = 2;
          default: m_phase = 0;
        endcase
        m_ticks = 0; m_nonext = 0;
      end else begin
        m_ticks++;
        if (m_phase == 1 && !e) m_nonext++;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    int cnt_g, cnt_y;

    // Scenario 1: defaults, free-running tick, no priority.
    tick = 1'b1; prio = '0;
    do_reset();
    for (int i = 0; i < 110; i++) step();
    chk("s1_c0_allred", rec_r[0], 1'b1);
    chk("s1_c0_active", rec_a[0], 2'd0);
    chk("s1_c1_done", rec_d[1], 1'b1);
    chk("s1_c2_green", rec_g[2], 4'b0001);
    chk("s1_c21_green", rec_g[21], 4'b0001);
    chk("s1_c21_done", rec_d[21], 1'b1);
    chk("s1_c22_yellow", rec_y[22], 4'b0001);
    chk("s1_c25_done", rec_d[25], 1'b1);
    chk("s1_c26_allred", rec_r[26], 1'b1);
    chk("s1_c27_done", rec_d[27], 1'b1);
    chk("s1_c28_green", rec_g[28], 4'b0010);
    chk("s1_c105_green", rec_g[105], 4'b0000);
    chk("s1_c106_green", rec_g[106], 4'b0001);

    // Scenario 2: own-approach priority extends green to the ceiling.
    prio = 4'b0001;
    do_reset();
    for (int i = 0; i < 60; i++) step();
    chk("s2_c41_green", rec_g[41], 4'b0001);
    chk("s2_c41_done", rec_d[41], 1'b1);
    chk("s2_c42_yellow", rec_y[42], 4'b0001);
    chk("s2_c48_green", rec_g[48], 4'b0010);

    // Scenario 3: early request from approach 3 waits for minimum green.
    prio = '0;
    do_reset();
    for (int i = 0; i < 21; i++) begin
      if (i == 4) prio = 4'b1000;
      step();
    end
    chk("s3_c6_green", rec_g[6], 4'b0001);
    chk("s3_c7_yellow", rec_y[7], 4'b0001);
    chk("s3_c12_allred", rec_r[12], 1'b1);
    chk("s3_c13_green", rec_g[13], 4'b1000);
    chk("s3_c13_active", rec_a[13], 2'd3);

    // Scenario 4: multi-hot request during all-red after approach 0.
    prio = '0;
    do_reset();
    for (int i = 0; i < 41; i++) begin
      if (i == 26) prio = 4'b0110;
      step();
    end
    chk("s4_c28_green", rec_g[28], 4'b0010);
    chk("s4_c31_green", rec_g[31], 4'b0010);
    chk("s4_c32_done", rec_d[32], 1'b1);
    chk("s4_c33_yellow", rec_y[33], 4'b0010);

    // Scenario 5: reset pulse mid-yellow, then exact replay.
    prio = '0;
    do_reset();
    for (int i = 0; i < 23; i++) step();
    chk("s5_pre_yellow", rec_y[22], 4'b0001);
    do_reset();
    for (int i = 0; i < 30; i++) step();
    chk("s5_c0_allred", rec_r[0], 1'b1);
    chk("s5_c0_green", rec_g[0], 4'b0000);
    chk("s5_c0_yellow", rec_y[0], 4'b0000);
    chk("s5_c0_active", rec_a[0], 2'd0);
    chk("s5_c2_green", rec_g[2], 4'b0001);
    chk("s5_c28_green", rec_g[28], 4'b0010);

    // Scenario 6: tick on every 4th clock stretches phases by 4x.
    prio = '0;
    tick = 1'b1;
    do_reset();
    for (int i = 0; i < 120; i++) begin
      tick = (i % 4 == 0);
      step();
    end
    cnt_g = 0; cnt_y = 0;
    for (int i = 0; i < 120; i++) begin
      if (rec_g[i] == 4'b0001) cnt_g++;
      if (rec_y[i] == 4'b0001) cnt_y++;
    end
    chk("s6_green_len", cnt_g, 80);
    chk("s6_yellow_len", cnt_y, 16);

    // Scenario 7: random priority, tick and occasional reset.
    tick = 1'b1;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      tick = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0)
        prio = 4'($urandom_range(0, 15));
      else if ($urandom_range(0, 7) == 0)
        prio = '0;
      rst = ($urandom_range(0, 399) == 0);
      step();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
